mouse_packet_decoder: RTL
=========================

Name: mouse_packet_decoder

Overview:
- Converts the PS/2 mouse byte stream into the xpos/ypos/left signals consumed by event_checker and card_press_checker.
- Bytes arrive one at a time from a PS/2 serial receiver as rx_data/rx_valid.
- The block frames 3-byte movement packets, accumulates signed deltas into absolute screen coordinates clamped to 1024x768, and reports button state.
- It sits between the PS/2 receiver and the game logic, in the clk (65 MHz) domain.

Parameters:
X_MAX, 1023, largest legal xpos
Y_MAX, 767, largest legal ypos
X_INIT, 512, xpos after reset
Y_INIT, 384, ypos after reset
TIMEOUT_CYCLES, 65000, idle clocks inside a packet before resync (1 ms at 65 MHz)

Ports:
clk  input  1  system clock, 65 MHz
rst  input  1  asynchronous, active-low reset
rx_data  input  8  received PS/2 byte
rx_valid  input  1  one-cycle strobe: rx_data valid
xpos  output  12  cursor x, 0..X_MAX
ypos  output  12  cursor y, 0..Y_MAX, 0 = top
left  output  1  left button held
right  output  1  right button held
wheel  output  4  signed wheel delta of last packet
packet_done  output  1  one-cycle pulse: outputs just updated
sync_err  output  1  one-cycle pulse: byte discarded or packet aborted

Behaviour:
- Reset (rst=0, async):
  - state=BYTE0, xpos=X_INIT, ypos=Y_INIT.
  - left=0, right=0, wheel=0, packet_done=0, sync_err=0.
  - Timeout counter=0.
- State BYTE0:
  - On rx_valid with rx_data[3]=1: latch byte as status, go to BYTE1.
  - On rx_valid with rx_data[3]=0: discard byte, pulse sync_err next cycle, stay in BYTE0.
- State BYTE1: on rx_valid, latch dx byte, go to BYTE2.
- State BYTE2: on rx_valid, latch dy byte, go to UPDATE (BYTE3 when the optional feature is enabled).
- State UPDATE (single cycle), then return to BYTE0:
  - dx = {status[4], dx_byte} and dy = {status[5], dy_byte}, each 9-bit two's complement.
  - New x = xpos + dx and new y = ypos - dy (PS/2 y is positive-up), computed in 13-bit signed.
  - Clamp each result to [0, X_MAX] / [0, Y_MAX].
  - Overflow: status[6] set suppresses the x update; status[7] set suppresses the y update.
  - left=status[0] and right=status[1] are always updated.
  - xpos/ypos/left/right register at the end of UPDATE. packet_done is high in the first cycle the new values are visible.
- Latency: last packet byte accepted in cycle N → new outputs and packet_done in cycle N+2.
- rx_valid during UPDATE: the byte is treated as the BYTE0 candidate; it is not lost.
- Timeout:
  - In BYTE1/BYTE2/BYTE3, the counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: partial packet dropped, state=BYTE0, sync_err pulses, outputs unchanged.
  - Counter is held at 0 in BYTE0.
- Simultaneous rx_valid and timeout expiry: the byte wins; it is accepted and the counter clears.
- Reset mid-packet: partial packet discarded, all outputs return to reset values.
- packet_done and sync_err are never high in the same cycle.

Optional Feature:
MOUSE_WHEEL_EN
- Defined: 4-byte IntelliMouse packets.
  - State BYTE3 follows BYTE2 and latches the 4th byte.
  - UPDATE sets wheel = byte3[3:0], signed.
  - Timeout applies in BYTE3.
- Undefined: 3-byte packets, no BYTE3 state, wheel tied to 4'h0.
- Port list is identical in both builds.

Test Plan:
- Reset, then bytes 0x09, 0x05, 0x03 → xpos=517, ypos=381, left=1, right=0; packet_done pulses exactly once, 2 cycles after the 3rd rx_valid.
- From 512/384, bytes 0x38, 0xF0, 0xF0 (dx=-16, dy=-16) → xpos=496, ypos=400, left=0.
- Drive xpos to 1020, then bytes 0x08, 0x0A, 0x00 → xpos=1023; 0x28, 0x00, 0x7F repeated until ypos=767 and stays 767.
- Byte 0x00 in BYTE0 → sync_err pulse, no state change; following 0x08, 0x01, 0x00 → xpos +1.
- Bytes 0x08, 0x05, then 65000 idle cycles → sync_err pulse, outputs unchanged. Next 0x09, 0x00, 0x00 decodes normally, left=1.
- Bytes 0x49, 0x7F, 0x00 → xpos unchanged (X overflow), left=1. With MOUSE_WHEEL_EN, 4th byte 0x0F → wheel=4'hF (-1).

Source files
------------

// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: frames PS/2 mouse packets into a clamped cursor position and button state.
// Optional build macro MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets with a signed wheel delta.
module mouse_packet_decoder #(
  parameter int X_MAX          = 1023,
  parameter int Y_MAX          = 767,
  parameter int X_INIT         = 512,
  parameter int Y_INIT         = 384,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic [3:0]  wheel,
  output logic        packet_done,
  output logic        sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [12:0] XM = 13'(X_MAX);
  localparam logic signed [12:0] YM = 13'(Y_MAX);

`ifdef MOUSE_WHEEL_EN
  typedef enum logic [2:0] {BYTE0, BYTE1, BYTE2, BYTE3, UPDATE} state_t;
`else
  typedef enum logic [2:0] {BYTE0, BYTE1, BYTE2, UPDATE} state_t;
`endif

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Only the status bits that are used: {ovf_y, ovf_x, sign_y, sign_x, right, left}
  logic [5:0] st_q, st_d;
  logic [7:0] dx_q, dx_d, dy_q, dy_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic left_q, left_d, right_q, right_d;
  logic done_q, done_d, err_q, err_d, pend_q, pend_d, err_ev;
  logic signed [12:0] nx, ny;
  logic [11:0] xclamp, yclamp;
`ifdef MOUSE_WHEEL_EN
  logic [3:0] wb_q, wb_d, wheel_q, wheel_d;
`endif

  assign nx = $signed({1'b0, xpos_q}) + $signed({{5{st_q[2]}}, dx_q});
  assign ny = $signed({1'b0, ypos_q}) - $signed({{5{st_q[3]}}, dy_q});
  assign xclamp = nx[12] ? 12'd0 : (nx > XM) ? XM[11:0] : nx[11:0];
  assign yclamp = ny[12] ? 12'd0 : (ny > YM) ? YM[11:0] : ny[11:0];

  // Packet framing, timeout, position update; an error that coincides with packet_done is deferred a cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    st_d    = st_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    left_d  = left_q;
    right_d = right_q;
`ifdef MOUSE_WHEEL_EN
    wb_d    = wb_q;
    wheel_d = wheel_q;
`endif
    done_d  = 1'b0;
    err_ev  = 1'b0;
    if (state_q == UPDATE) begin
      xpos_d  = st_q[4] ? xpos_q : xclamp;
      ypos_d  = st_q[5] ? ypos_q : yclamp;
      left_d  = st_q[0];
      right_d = st_q[1];
`ifdef MOUSE_WHEEL_EN
      wheel_d = wb_q;
`endif
      done_d  = 1'b1;
      state_d = BYTE0;
    end
    if (state_q == BYTE0 || state_q == UPDATE) begin
      if (rx_valid && rx_data[3]) begin
        st_d    = {rx_data[7:4], rx_data[1:0]};
        state_d = BYTE1;
      end else begin
        err_ev = rx_valid;
      end
    end else if (rx_valid) begin
      if (state_q == BYTE1) begin
        dx_d    = rx_data;
        state_d = BYTE2;
`ifdef MOUSE_WHEEL_EN
      end else if (state_q == BYTE2) begin
        dy_d    = rx_data;
        state_d = BYTE3;
      end else begin
        wb_d    = rx_data[3:0];
        state_d = UPDATE;
      end
`else
      end else begin
        dy_d    = rx_data;
        state_d = UPDATE;
      end
`endif
    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = BYTE0;
      err_ev  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d  = (err_ev | pend_q) & ~done_d;
    pend_d = (err_ev | pend_q) & done_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BYTE0;
      cnt_q   <= '0;
      st_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      xpos_q  <= 12'(X_INIT);
      ypos_q  <= 12'(Y_INIT);
      left_q  <= 1'b0;
      right_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      wb_q    <= '0;
      wheel_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      left_q  <= left_d;
      right_q <= right_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
`ifdef MOUSE_WHEEL_EN
      wb_q    <= wb_d;
      wheel_q <= wheel_d;
`endif
    end
  end

  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign left        = left_q;
  assign right       = right_q;
  assign packet_done = done_q;
  assign sync_err    = err_q;
`ifdef MOUSE_WHEEL_EN
  assign wheel = wheel_q;
`else
  assign wheel = 4'h0;
`endif

endmodule
